// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [3:0] ADDR_EN        = 4'h0;
  localparam logic [3:0] ADDR_MODE      = 4'h1;
  localparam logic [3:0] ADDR_THR       = 4'h2;
  localparam logic [3:0] ADDR_PRIO_BASE = 4'h4;

  localparam int NONE_ID = 0;

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational priority arbiter: highest priority wins, lowest ID on a tie.
module irq_prio_arb
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int PRIO_W  = 2,
  parameter int ID_W    = $clog2(NUM_SRC+1)
) (
  input  logic [NUM_SRC-1:0]             eligible,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
  output logic [ID_W-1:0]                win_id,
  output logic                           win_valid
);

  logic [PRIO_W-1:0] best;

  // Scan upward by ID; strict compare keeps the lower ID on equal priority.
  always_comb begin
    win_id    = ID_W'(NONE_ID);
    win_valid = 1'b0;
    best      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!win_valid || prio[i] > best)) begin
        win_valid = 1'b1;
        best      = prio[i];
        win_id    = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/mask/priority, one registered request, claim/complete.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on every interrupt input.
//
// state   | meaning
// IDLE    | nothing requested; raise a request when any source is eligible
// REQ     | irq_req=1, irq_id frozen until claim or the source becomes ineligible
// SERVICE | claimed source in service (busy=1); waits for a matching complete
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int PRIO_W  = 2,
  parameter int ID_W    = $clog2(NUM_SRC+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] interrupt,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               claim,
  input  logic               complete,
  input  logic [ID_W-1:0]    complete_id,
  output logic               busy
);

  logic [NUM_SRC-1:0]             sampled, in_q, pending, pending_d;
  logic [NUM_SRC-1:0]             en, en_d, mode, mode_d, clr, mask_d, eligible;
  logic [PRIO_W-1:0]              thr, thr_d;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio, prio_d;
  irq_state_e                     state, state_d;
  logic [ID_W-1:0]                irq_id_d, svc_id, svc_id_d, win_id;
  logic                           win_valid, req_ok;
  logic                           unused_wdata;

  assign unused_wdata = ^cfg_wdata;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;

  // Two-flop synchronizer ahead of edge/level sampling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= interrupt;
      sync2 <= sync1;
    end
  end
  assign sampled = sync2;
`else
  assign sampled = interrupt;
`endif

  // Post-write config values; REQ uses them so a disabling write drops irq_req at once.
  always_comb begin
    en_d   = en;
    mode_d = mode;
    thr_d  = thr;
    prio_d = prio;
    if (cfg_we) begin
      case (cfg_addr)
        ADDR_EN:   en_d   = cfg_wdata[NUM_SRC-1:0];
        ADDR_MODE: mode_d = cfg_wdata[NUM_SRC-1:0];
        ADDR_THR:  thr_d  = cfg_wdata[PRIO_W-1:0];
        default: begin
          for (int i = 0; i < NUM_SRC; i++)
            if (cfg_addr == ADDR_PRIO_BASE + 4'(i)) prio_d[i] = cfg_wdata[PRIO_W-1:0];
        end
      endcase
    end
  end

  // Config registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= '0;
      mode <= '0;
      thr  <= '0;
      prio <= '0;
    end else begin
      en   <= en_d;
      mode <= mode_d;
      thr  <= thr_d;
      prio <= prio_d;
    end
  end

  // Config readback, unmapped addresses and unused bits read 0.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_EN:   cfg_rdata[NUM_SRC-1:0] = en;
      ADDR_MODE: cfg_rdata[NUM_SRC-1:0] = mode;
      ADDR_THR:  cfg_rdata[PRIO_W-1:0]  = thr;
      default: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (cfg_addr == ADDR_PRIO_BASE + 4'(i)) cfg_rdata[PRIO_W-1:0] = prio[i];
      end
    endcase
  end

  // Eligibility of each source and whether the requested source is still eligible.
  always_comb begin
    req_ok = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] && en[i] && (prio[i] > thr);
      if (irq_id == ID_W'(i + 1))
        req_ok = pending[i] && en_d[i] && (prio_d[i] > thr_d);
    end
  end

  irq_prio_arb #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) u_arb (
    .eligible  (eligible),
    .prio      (prio),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // FSM next state; claim is evaluated before any same-cycle config effect.
  always_comb begin
    state_d  = state;
    irq_id_d = irq_id;
    svc_id_d = svc_id;
    clr      = '0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_d  = REQ;
          irq_id_d = win_id;
        end
      end
      REQ: begin
        if (claim) begin
          state_d  = SERVICE;
          svc_id_d = irq_id;
          irq_id_d = ID_W'(NONE_ID);
          for (int i = 0; i < NUM_SRC; i++) clr[i] = (irq_id == ID_W'(i + 1));
        end else if (!req_ok) begin
          state_d  = IDLE;
          irq_id_d = ID_W'(NONE_ID);
        end
      end
      SERVICE: begin
        if (complete && complete_id == svc_id) begin
          state_d  = IDLE;
          svc_id_d = ID_W'(NONE_ID);
        end
      end
      default: begin
        state_d  = IDLE;
        irq_id_d = ID_W'(NONE_ID);
        svc_id_d = ID_W'(NONE_ID);
      end
    endcase
  end

  // Pending update: edge sets (winning over claim-clear), level follows input minus in-service mask.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      mask_d[i] = (state_d == SERVICE) && (svc_id_d == ID_W'(i + 1));
      if (mode[i]) pending_d[i] = (pending[i] && !clr[i]) || (sampled[i] && !in_q[i]);
      else         pending_d[i] = sampled[i] && !mask_d[i];
    end
  end

  // Input sample and pending registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= '0;
      pending <= '0;
    end else begin
      in_q    <= sampled;
      pending <= pending_d;
    end
  end

  // FSM state and registered IDs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      irq_id <= '0;
      svc_id <= '0;
    end else begin
      state  <= state_d;
      irq_id <= irq_id_d;
      svc_id <= svc_id_d;
    end
  end

  assign irq_req = (state == REQ);
  assign busy    = (state == SERVICE);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (default build, no input synchronizer).
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  interrupt;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic        claim, complete;
  logic [1:0]  complete_id;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_controller dut (
    .clk(clk), .reset(rst_n), .interrupt(interrupt),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_req(irq_req), .irq_id(irq_id), .claim(claim), .complete(complete),
    .complete_id(complete_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic serve(input logic [1:0] id);
    claim = 1'b1;
    tick();
    claim = 1'b0; complete = 1'b1; complete_id = id;
    tick();
    complete = 1'b0; complete_id = 2'd0;
  endtask

  task automatic pulse(input logic [1:0] v);
    interrupt = v;
    tick();
    interrupt = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    interrupt = '0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    claim = 0; complete = 0; complete_id = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 16; a++) begin
      cfg_addr = 4'(a);
      #1;
      n_cmp++;
      if (cfg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %0h expected 0", a, cfg_rdata); end
    end
    n_cmp++;
    if ({irq_req, busy, irq_id} !== 4'b0) begin n_fail++; $display("FAIL reset_outputs: got req=%0b busy=%0b id=%0d expected 0", irq_req, busy, irq_id); end
  endtask

  task automatic test_basic();
    cfg_write(4'h0, 32'd3); cfg_write(4'h1, 32'd3); cfg_write(4'h4, 32'd1); cfg_write(4'h2, 32'd0);
    n_cmp++;
    if (cfg_rdata !== 32'd0) begin n_fail++; $display("FAIL basic_thr_read: got %0h expected 0", cfg_rdata); end
    cfg_addr = 4'h4; #1;
    n_cmp++;
    if (cfg_rdata !== 32'd1) begin n_fail++; $display("FAIL basic_prio_read: got %0h expected 1", cfg_rdata); end
    pulse(2'b01);
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_n1: got req=%0b expected 0", irq_req); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL basic_n2: got req=%0b id=%0d expected req=1 id=1", irq_req, irq_id); end
    claim = 1'b1; tick(); claim = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_claim: got busy=%0b req=%0b expected busy=1 req=0", busy, irq_req); end
    complete = 1'b1; complete_id = 2'd1; tick(); complete = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_complete: got busy=%0b req=%0b expected 0/0", busy, irq_req); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got req=%0b expected 0", irq_req); end
  endtask

  task automatic test_arbitration();
    cfg_write(4'h4, 32'd2); cfg_write(4'h5, 32'd3);
    pulse(2'b11); tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd2) begin n_fail++; $display("FAIL arb_high: got req=%0b id=%0d expected req=1 id=2", irq_req, irq_id); end
    serve(2'd2); tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL arb_queued: got req=%0b id=%0d expected req=1 id=1", irq_req, irq_id); end
    serve(2'd1);
    cfg_write(4'h4, 32'd3);
    pulse(2'b11); tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL arb_tie: got req=%0b id=%0d expected req=1 id=1", irq_req, irq_id); end
    serve(2'd1); tick();
    serve(2'd2); tick();
  endtask

  task automatic test_threshold();
    cfg_write(4'h2, 32'd2); cfg_write(4'h4, 32'd2);
    pulse(2'b01); repeat (3) tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL thr_block: got req=%0b expected 0", irq_req); end
    cfg_write(4'h2, 32'd0); tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL thr_lower: got req=%0b id=%0d expected req=1 id=1", irq_req, irq_id); end
    cfg_write(4'h0, 32'd0);
    n_cmp++;
    if (irq_req !== 1'b0) begin n_fail++; $display("FAIL disable_drop: got req=%0b expected 0", irq_req); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL disable_idle: got req=%0b busy=%0b expected 0/0", irq_req, busy); end
    cfg_write(4'h0, 32'd3); tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL reenable: got req=%0b id=%0d expected req=1 id=1", irq_req, irq_id); end
    serve(2'd1); tick();
  endtask

  task automatic test_no_nesting();
    cfg_write(4'h4, 32'd2); cfg_write(4'h5, 32'd3);
    pulse(2'b01); tick();
    claim = 1'b1; tick(); claim = 1'b0;
    pulse(2'b10); repeat (2) tick();
    n_cmp++;
    if (irq_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nest_block: got req=%0b busy=%0b expected 0/1", irq_req, busy); end
    complete = 1'b1; complete_id = 2'd2; tick(); complete = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || irq_req !== 1'b0) begin n_fail++; $display("FAIL stale_complete: got busy=%0b req=%0b expected 1/0", busy, irq_req); end
    complete = 1'b1; complete_id = 2'd1; tick(); complete = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL nest_complete: got busy=%0b expected 0", busy); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd2) begin n_fail++; $display("FAIL nest_follow: got req=%0b id=%0d expected req=1 id=2", irq_req, irq_id); end
    serve(2'd2); tick();
  endtask

  task automatic test_level_reset();
    cfg_write(4'h1, 32'd0);
    interrupt = 2'b01; repeat (2) tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL level_req: got req=%0b id=%0d expected req=1 id=1", irq_req, irq_id); end
    claim = 1'b1; tick(); claim = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (irq_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL level_mask: got req=%0b busy=%0b expected 0/1", irq_req, busy); end
    complete = 1'b1; complete_id = 2'd1; tick(); complete = 1'b0;
    n_cmp++;
    if (irq_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL level_c1: got req=%0b busy=%0b expected 0/0", irq_req, busy); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL level_c2: got req=%0b id=%0d expected req=1 id=1", irq_req, irq_id); end
    claim = 1'b1; tick(); claim = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || irq_req !== 1'b0 || irq_id !== 2'd0) begin n_fail++; $display("FAIL async_reset: got busy=%0b req=%0b id=%0d expected 0", busy, irq_req, irq_id); end
    cfg_addr = 4'h0; #1;
    n_cmp++;
    if (cfg_rdata !== 32'd0) begin n_fail++; $display("FAIL async_reset_cfg: got %0h expected 0", cfg_rdata); end
    interrupt = 2'b00;
    tick(); rst_n = 1'b1; tick();
  endtask

  // Randomized run against a reference model of the documented behaviour.
  task automatic test_random();
    int m_en, m_mode, m_thr, m_req, m_svc;
    int m_prio[2], m_pend[2], m_prev[2];
    int n_en, n_mode, n_thr, n_req, n_svc, clr, exp_rd, in_b;
    int n_prio[2], n_pend[2];
    logic [1:0] iv, cid;
    logic we, cl, cp;
    logic [3:0] a;
    logic [31:0] wd;
    do_reset();
    m_en = 0; m_mode = 0; m_thr = 0; m_req = 0; m_svc = 0;
    m_prio = '{0, 0}; m_pend = '{0, 0}; m_prev = '{0, 0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      iv = 2'($urandom_range(0, 3));
      we = ($urandom_range(0, 5) == 0);
      a  = 4'($urandom_range(0, 7));
      wd = $urandom;
      cl = ($urandom_range(0, 2) == 0);
      cp = ($urandom_range(0, 2) == 0);
      cid = 2'($urandom_range(0, 3));
      interrupt = iv; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
      claim = cl; complete = cp; complete_id = cid;
      n_en = m_en; n_mode = m_mode; n_thr = m_thr; n_prio = m_prio;
      if (we) begin
        if (a == 0) n_en = int'(wd[1:0]);
        if (a == 1) n_mode = int'(wd[1:0]);
        if (a == 2) n_thr = int'(wd[1:0]);
        if (a == 4) n_prio[0] = int'(wd[1:0]);
        if (a == 5) n_prio[1] = int'(wd[1:0]);
      end
      n_req = m_req; n_svc = m_svc; clr = 0;
      if (m_req != 0) begin
        if (cl) begin
          n_svc = m_req; clr = m_req; n_req = 0;
        end else if (!(m_pend[m_req-1] != 0 && ((n_en >> (m_req-1)) & 1) != 0 && n_prio[m_req-1] > n_thr))
          n_req = 0;
      end else if (m_svc != 0) begin
        if (cp && int'(cid) == m_svc) n_svc = 0;
      end else begin
        for (int p = 3; p >= 1; p--)
          for (int s = 1; s <= 2; s++)
            if (n_req == 0 && p > m_thr && m_prio[s-1] == p && m_pend[s-1] != 0 && ((m_en >> (s-1)) & 1) != 0)
              n_req = s;
      end
      for (int s = 1; s <= 2; s++) begin
        in_b = int'(iv[s-1]);
        if (((m_mode >> (s-1)) & 1) != 0)
          n_pend[s-1] = ((m_pend[s-1] != 0 && clr != s) || (in_b != 0 && m_prev[s-1] == 0)) ? 1 : 0;
        else
          n_pend[s-1] = (in_b != 0 && n_svc != s) ? 1 : 0;
        m_prev[s-1] = in_b;
      end
      m_en = n_en; m_mode = n_mode; m_thr = n_thr; m_prio = n_prio;
      m_req = n_req; m_svc = n_svc; m_pend = n_pend;
      tick();
      case (a)
        4'h0: exp_rd = m_en;
        4'h1: exp_rd = m_mode;
        4'h2: exp_rd = m_thr;
        4'h4: exp_rd = m_prio[0];
        4'h5: exp_rd = m_prio[1];
        default: exp_rd = 0;
      endcase
      n_cmp++;
      if (irq_req !== (m_req != 0) || irq_id !== 2'(m_req) || busy !== (m_svc != 0)) begin
        n_fail++;
        $display("FAIL rand_out cyc%0d: got req=%0b id=%0d busy=%0b expected req=%0b id=%0d busy=%0b",
                 cyc, irq_req, irq_id, busy, m_req != 0, m_req, m_svc != 0);
      end
      n_cmp++;
      if (cfg_rdata !== 32'(exp_rd)) begin n_fail++; $display("FAIL rand_rdata cyc%0d addr%0d: got %0h expected %0h", cyc, a, cfg_rdata, exp_rd); end
    end
    interrupt = '0; cfg_we = 0; claim = 0; complete = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_threshold();
    test_no_nesting();
    test_level_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
